// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
// Shares one downstream memory port between the fetch stage and the
// load/store unit. At most one downstream transaction is in flight.
//
// Build option: define MEMORY_ARBITER_ROUND_ROBIN_EN to alternate grants when
// both requesters ask in the same cycle. Left undefined, load/store always
// wins over fetch.
//
// Handshake rules: a request transfers in a cycle where its valid and ready
// are both high; a requester holds valid and payload stable until it sees
// ready. Ready is a combinational function of valid and arbiter state and is
// only ever offered in IDLE. Downstream, mem_req_valid holds the latched
// fields stable until mem_req_ready. Response pulses (fetch_rsp_valid /
// ls_rsp_valid) are single-cycle with no back-pressure; the data outputs hold
// the last response value.
module memory_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              fetch_req_valid,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_req_ready,
    output logic              fetch_rsp_valid,
    output logic [DATA_W-1:0] fetch_rsp_data,
    // load/store port
    input  logic              ls_req_valid,
    input  logic              ls_req_write,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    // downstream memory port
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic              mem_req_owner,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    // status
    output logic              mem_timeout,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // owner encoding: 0 = fetch, 1 = load/store
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              r_owner;
    logic [7:0]        r_wait_cnt;
    logic              r_timeout;
    logic              r_fetch_rsp;
    logic              r_ls_rsp;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_pick_ls;
    logic              w_can_grant;
    logic              w_rsp_pulse;
    logic              w_in_wait;
    logic              w_rsp_done;
    logic              w_tmo_hit;
    logic              w_finish;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic              r_last_grant;

    // On a tie, grant whichever requester did not win the previous grant.
    assign w_pick_ls = ls_req_valid && (!fetch_req_valid || !r_last_grant);

    // Remember who won each grant; reset leaves load/store as last winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_can_grant) begin
            r_last_grant <= w_pick_ls;
        end
    end
`else
    // Fixed priority: load/store beats fetch whenever it is asking.
    assign w_pick_ls = ls_req_valid;
`endif

    // A grant needs IDLE, a requester, and no response pulse this cycle so a
    // new grant never overlaps the previous transaction's completion.
    assign w_rsp_pulse = r_fetch_rsp || r_ls_rsp;
    assign w_can_grant = (r_state == S_IDLE) && !reset && !w_rsp_pulse &&
                         (fetch_req_valid || ls_req_valid);

    assign w_in_wait  = (r_state == S_WAIT);
    assign w_rsp_done = w_in_wait && mem_rsp_valid;
    // The current WAIT cycle is the TIMEOUT_CYCLES-th without a response.
    assign w_tmo_hit  = w_in_wait && !mem_rsp_valid &&
                        (({24'd0, r_wait_cnt} + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign w_finish   = w_rsp_done || w_tmo_hit;

    // Transaction sequencing: IDLE -> ISSUE -> WAIT -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_can_grant)   r_state <= S_ISSUE;
                S_ISSUE: if (mem_req_ready) r_state <= S_WAIT;
                S_WAIT:  if (w_finish)      r_state <= S_IDLE;
                default:                    r_state <= S_IDLE;
            endcase
        end
    end

    // Capture the winning request's fields at grant; held until next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_owner <= 1'b0;
        end else if (w_can_grant) begin
            r_addr  <= w_pick_ls ? ls_req_addr : fetch_req_addr;
            r_wdata <= w_pick_ls ? ls_req_wdata : '0;
            r_write <= w_pick_ls && ls_req_write;
            r_owner <= w_pick_ls;
        end
    end

    // Count WAIT cycles (saturating) and raise the sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_finish || !w_in_wait) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // One-cycle response pulse to the owner; data is zero on a timeout abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_rsp <= 1'b0;
            r_ls_rsp    <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_fetch_rsp <= w_finish && !r_owner;
            r_ls_rsp    <= w_finish && r_owner;
            if (w_rsp_done) begin
                r_rsp_data <= mem_rsp_data;
            end else if (w_tmo_hit) begin
                r_rsp_data <= '0;
            end
        end
    end

    assign fetch_req_ready = w_can_grant && !w_pick_ls;
    assign ls_req_ready    = w_can_grant && w_pick_ls;
    assign fetch_rsp_valid = r_fetch_rsp;
    assign ls_rsp_valid    = r_ls_rsp;
    assign fetch_rsp_data  = r_rsp_data;
    assign ls_rsp_data     = r_rsp_data;
    assign mem_req_valid   = (r_state == S_ISSUE);
    assign mem_req_write   = r_write;
    assign mem_req_addr    = r_addr;
    assign mem_req_wdata   = r_wdata;
    assign mem_req_owner   = r_owner;
    assign mem_timeout     = r_timeout;
    assign dbg_state       = r_state;

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: memory_address_t width.
REQ-002 Parameter DATA_W, default 64: bus payload width (one fetched_instruction_data_t).
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT_RSP cycles before abort.
REQ-004 Clock: clk  in  1; one clock; all state on rising edge.
REQ-005 Reset: reset  in  1; asynchronous, active-high.
REQ-006 fetch_req_valid in 1 / fetch_req_addr in ADDR_W: read request from the fetch stage.
REQ-007 fetch_req_ready out 1: fetch request accepted this cycle.
REQ-008 fetch_rsp_valid out 1 / fetch_rsp_data out DATA_W: read response to fetch.
REQ-009 ls_req_valid in 1 / ls_req_write in 1 / ls_req_addr in ADDR_W / ls_req_wdata in DATA_W: load/store request.
REQ-010 ls_req_ready out 1; ls_rsp_valid out 1 / ls_rsp_data out DATA_W: load/store accept and response.
REQ-011 mem_req_valid out 1, mem_req_write out 1, mem_req_addr out ADDR_W, mem_req_wdata out DATA_W, mem_req_owner out 1 (0 = fetch, 1 = load/store): downstream request.
REQ-012 mem_req_ready in 1; mem_rsp_valid in 1 / mem_rsp_data in DATA_W: downstream handshake and response.
REQ-013 mem_timeout out 1: sticky timeout error flag.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and WAIT_RSP; at most one downstream transaction is outstanding.
REQ-015 IDLE, at least one req_valid high: pick a winner, latch its addr/wdata/write/owner, pulse only the winner's req_ready for 1 cycle, go to ISSUE.
REQ-016 IDLE, no req_valid: stay in IDLE; all ready and rsp_valid outputs low.
REQ-017 ISSUE: mem_req_valid = 1 with the latched fields held stable; on mem_req_ready = 1 go to WAIT_RSP.
REQ-018 A request accepted in IDLE at cycle N SHALL drive mem_req_valid from cycle N+1.
REQ-019 WAIT_RSP: on mem_rsp_valid, register mem_rsp_data and pulse the latched owner's rsp_valid at the next cycle; clear the timeout counter; go to IDLE.
REQ-020 Writes SHALL also complete on mem_rsp_valid; ls_rsp_data carries mem_rsp_data unchanged.
REQ-021 mem_rsp_valid outside WAIT_RSP SHALL be ignored, with no output change.
REQ-022 The 8-bit-saturating (ADDR-independent) wait counter SHALL count WAIT_RSP cycles. On reaching TIMEOUT_CYCLES, set mem_timeout, pulse the owner's rsp_valid with data 0, and go to IDLE.
REQ-023 The non-winning requester SHALL see req_ready low and must hold its request; the arbiter never drops a held request.
REQ-024 Only one of fetch_rsp_valid / ls_rsp_valid SHALL be high in any cycle.
REQ-025 A new grant SHALL occur no earlier than the cycle after a rsp_valid pulse (IDLE re-entry).

Reset
REQ-026 Reset SHALL force IDLE, clear all latches and the counter, set last_grant = load/store, and drive every output to 0, including mem_timeout.
REQ-027 Reset asserted mid-transaction SHALL abandon it without any rsp_valid pulse.

Configuration
REQ-028 With MEMORY_ARBITER_ROUND_ROBIN_EN defined, a tie SHALL grant the requester not granted last (last_grant updates on every grant).
REQ-029 Without the macro, fixed priority SHALL apply: load/store always beats fetch, and last_grant is unused.

Verification
REQ-030 Fetch only, addr 0x100, mem_req_ready = 1, response 0xDEADBEEF_CAFEF00D 2 cycles later -> fetch_req_ready at N; mem_req_valid at N+1 with owner 0; fetch_rsp_valid one cycle after mem_rsp_valid with that data.
REQ-031 Both requesters valid at the same cycle, repeated 4 times, with the macro defined -> grant order fetch, ls, fetch, ls; without the macro -> ls every time while ls_req_valid is held.
REQ-032 ls write addr 0x200, wdata 0x55, mem_req_ready held low for 3 cycles -> mem_req_valid held with stable fields for 4 cycles; ls_rsp_valid after the response.
REQ-033 Outstanding fetch, no mem_rsp_valid for 255 cycles -> mem_timeout = 1, fetch_rsp_valid pulse with data 0, FSM back in IDLE; mem_timeout stays 1 until reset.
REQ-034 Reset pulsed in WAIT_RSP, then a stray mem_rsp_valid -> no rsp_valid pulse; all outputs 0; a following ls request is granted normally.
